span_position_loader: RTL and testbench
=======================================

# span_position_loader

Upstream feeder for the SPAN CME margin peripheral. It accepts a stream of signed trade quantities and nets them into eight per-contract positions. On a flush request it acts as bus master into the margin peripheral: it writes the price scan range and all eight positions, waits a settle interval, reads back the initial margin and presents it as a one-cycle result pulse.

## Interface
- SETTLE_CYCLES, 4: idle cycles between the last position write and the margin read; legal range 1..255.

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- trade_valid  in  1  trade offered this cycle
- trade_ready  out  1  trade accepted when valid&ready
- trade_contract  in  3  contract index 0..7
- trade_qty  in  16  signed two's-complement quantity delta
- psr_in  in  16  price scan range, sampled on flush acceptance
- clear  in  1  zero all positions and overflow (IDLE only)
- flush  in  1  start a load/readback sequence (IDLE only)
- busy  out  1  sequence in progress
- cme_chipselect  out  1  bus select to margin peripheral
- cme_write  out  1  bus write strobe
- cme_read  out  1  bus read strobe
- cme_offset  out  6  register offset
- cme_writeData  out  16  write data
- cme_readData  in  16  margin peripheral read data (valid cycle after read strobe)
- margin  out  16  last captured initial margin
- margin_valid  out  1  one-cycle pulse when margin updates
- overflow  out  1  sticky accumulation overflow flag

## Operation
- State: pos[0..7] signed 16-bit, psr_q 16-bit, FSM {IDLE, WR_PSR, WR_POS, SETTLE, RD, CAP}, 3-bit write index, 8-bit settle counter.
- trade_ready = (state==IDLE) & ~clear & ~reset.
- Accepted trade: pos[trade_contract] <= pos[trade_contract] + trade_qty (17-bit signed sum, then width rule in Configuration).
- IDLE priority per cycle: clear > flush. clear zeroes pos[] and overflow and ignores flush that cycle. flush with a simultaneous accepted trade: trade is included in the written positions.
- IDLE -> WR_PSR on flush; psr_q <= psr_in.
- WR_PSR: cs=1, write=1, offset=0, data=psr_q. Next state WR_POS, index=0.
- WR_POS: cs=1, write=1, offset=index+1, data=pos[index]. index 7 (offset 8) -> SETTLE, counter=SETTLE_CYCLES.
- SETTLE: bus idle (cs/write/read=0). Decrement counter; at 1 -> RD.
- RD: cs=1, read=1, offset=0, write=0 -> CAP.
- CAP: bus idle; margin <= cme_readData; margin_valid pulses next cycle; -> IDLE.
- flush, clear and trades outside IDLE are ignored (trade_ready=0); positions persist across sequences.
- busy = (state != IDLE).
- Reset mid-sequence: FSM returns to IDLE immediately, all bus strobes drop next cycle, and no partial margin is reported.

## Timing
- Reset values: all bus outputs 0, cme_offset 0, cme_writeData 0, margin 0, margin_valid 0, overflow 0, busy 0, trade_ready 0 during reset, pos[] 0.
- All bus outputs registered; never both write and read high.
- flush sampled at edge k. WR_PSR strobe in cycle k+1. Offsets 1..8 in cycles k+2..k+9, one per cycle with no gaps. SETTLE occupies k+10..k+9+S. Read strobe at k+10+S. Capture at edge ending k+11+S. margin_valid high in cycle k+12+S, which is also the first cycle back in IDLE.
- Total flush-to-result latency: 12+SETTLE_CYCLES cycles. A new flush is accepted in the margin_valid cycle.
- A trade accepted at edge k updates pos at that edge and is visible to any later write.

## Configuration
- SPAN_LOADER_SAT_EN defined: 17-bit sum clamped to +32767 / -32768, and overflow set (sticky) whenever a clamp occurs.
- Undefined: sum truncated to 16 bits (two's-complement wrap); overflow tied to 0.

## Test plan
- Reset, trades (c0,+5),(c0,-2),(c7,+100), flush with psr_in=0x0320 -> bus writes off0=0x0320, off1=3, off2..off7=0, off8=100 in consecutive cycles.
- SETTLE_CYCLES=4, flush at edge k -> read strobe at k+14; cme_readData=0x1234 driven in k+15 -> margin=0x1234, margin_valid single pulse at k+16.
- Trade on c3 (+1) valid during WR_POS -> trade_ready=0, pos[3] unchanged, trade accepted once IDLE returns.
- clear and flush in same IDLE cycle with pos[1]=9 -> positions zeroed, busy stays 0, no bus activity.
- pos[2]=32767, trade +1: with SAT_EN -> pos[2]=32767, overflow=1; without -> pos[2]=-32768, overflow=0.
- reset asserted in SETTLE -> next cycle busy=0, strobes 0, margin_valid never pulses, pos[] zero.

Source files
------------

// File: rtl/span_position_loader_if.sv
// Trade handshake and margin-peripheral bus bundle for span_position_loader.
// The master modport is the loader's view; slave is the feeder/peripheral side.
interface span_position_loader_if;
    logic        trade_valid;
    logic        trade_ready;
    logic [2:0]  trade_contract;
    logic [15:0] trade_qty;
    logic        cme_chipselect;
    logic        cme_write;
    logic        cme_read;
    logic [5:0]  cme_offset;
    logic [15:0] cme_writeData;
    logic [15:0] cme_readData;

    modport master (
        input  trade_valid, trade_contract, trade_qty, cme_readData,
        output trade_ready, cme_chipselect, cme_write, cme_read, cme_offset, cme_writeData
    );

    modport slave (
        output trade_valid, trade_contract, trade_qty, cme_readData,
        input  trade_ready, cme_chipselect, cme_write, cme_read, cme_offset, cme_writeData
    );
endinterface

// File: rtl/span_position_loader.sv
// Nets signed trades into eight contract positions and loads them into the SPAN margin peripheral.
// Define SPAN_LOADER_SAT_EN for saturating accumulation with a sticky overflow flag (default: wrap).
module span_position_loader #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    span_position_loader_if.master bus,
    input  logic [15:0]            psr_in,
    input  logic                   clear,
    input  logic                   flush,
    output logic                   busy,
    output logic [15:0]            margin,
    output logic                   margin_valid,
    output logic                   overflow
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_PSR = 3'd1,
        ST_WR_POS = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RD     = 3'd4,
        ST_CAP    = 3'd5
    } state_t;

    // Returns {clamp_flag, new_position}.
    function automatic logic [16:0] accumulate(input logic [15:0] acc, input logic [15:0] delta);
`ifdef SPAN_LOADER_SAT_EN
        logic [16:0] sum;
        sum = {acc[15], acc} + {delta[15], delta};
        if (sum[16] != sum[15]) begin
            accumulate = {1'b1, (sum[16] ? 16'h8000 : 16'h7fff)};
        end else begin
            accumulate = {1'b0, sum[15:0]};
        end
`else
        accumulate = {1'b0, acc + delta};
`endif
    endfunction

    state_t      state_r;
    logic [15:0] pos_r [8];
    logic [2:0]  idx_r;
    logic [7:0]  settle_r;
    logic        cs_r;
    logic        wr_r;
    logic        rd_r;
    logic [5:0]  off_r;
    logic [15:0] wdata_r;
    logic [15:0] margin_r;
    logic        margin_valid_r;
    logic        overflow_r;
    logic        trade_ready_s;
    logic        trade_fire_s;
    logic [16:0] acc_s;

    // Trade acceptance and the candidate position for the addressed contract.
    always_comb begin
        trade_ready_s = (state_r == ST_IDLE) && !clear && !reset;
        trade_fire_s  = bus.trade_valid && trade_ready_s;
        acc_s         = accumulate(pos_r[bus.trade_contract], bus.trade_qty);
    end

    // Sequencer: bus outputs are registered one state ahead so each strobe lines up with its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            idx_r          <= 3'd0;
            settle_r       <= 8'd0;
            cs_r           <= 1'b0;
            wr_r           <= 1'b0;
            rd_r           <= 1'b0;
            off_r          <= 6'd0;
            wdata_r        <= 16'h0000;
            margin_r       <= 16'h0000;
            margin_valid_r <= 1'b0;
            overflow_r     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                pos_r[i] <= 16'h0000;
            end
        end else begin
            cs_r           <= 1'b0;
            wr_r           <= 1'b0;
            rd_r           <= 1'b0;
            off_r          <= 6'd0;
            wdata_r        <= 16'h0000;
            margin_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clear) begin
                        overflow_r <= 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            pos_r[i] <= 16'h0000;
                        end
                    end else begin
                        if (trade_fire_s) begin
                            pos_r[bus.trade_contract] <= acc_s[15:0];
                            overflow_r                <= overflow_r | acc_s[16];
                        end
                        // The write-data register doubles as the sampled scan range.
                        if (flush) begin
                            state_r <= ST_WR_PSR;
                            cs_r    <= 1'b1;
                            wr_r    <= 1'b1;
                            off_r   <= 6'd0;
                            wdata_r <= psr_in;
                        end
                    end
                end
                ST_WR_PSR: begin
                    state_r <= ST_WR_POS;
                    idx_r   <= 3'd0;
                    cs_r    <= 1'b1;
                    wr_r    <= 1'b1;
                    off_r   <= 6'd1;
                    wdata_r <= pos_r[0];
                end
                ST_WR_POS: begin
                    if (idx_r == 3'd7) begin
                        state_r  <= ST_SETTLE;
                        settle_r <= 8'(SETTLE_CYCLES);
                    end else begin
                        idx_r   <= idx_r + 3'd1;
                        cs_r    <= 1'b1;
                        wr_r    <= 1'b1;
                        off_r   <= {3'b000, idx_r} + 6'd2;
                        wdata_r <= pos_r[idx_r + 3'd1];
                    end
                end
                ST_SETTLE: begin
                    if (settle_r == 8'd1) begin
                        state_r <= ST_RD;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                    end else begin
                        settle_r <= settle_r - 8'd1;
                    end
                end
                ST_RD: begin
                    state_r <= ST_CAP;
                end
                ST_CAP: begin
                    state_r        <= ST_IDLE;
                    margin_r       <= bus.cme_readData;
                    margin_valid_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trade_ready    = trade_ready_s;
    assign bus.cme_chipselect = cs_r;
    assign bus.cme_write      = wr_r;
    assign bus.cme_read       = rd_r;
    assign bus.cme_offset     = off_r;
    assign bus.cme_writeData  = wdata_r;
    assign busy               = (state_r != ST_IDLE);
    assign margin             = margin_r;
    assign margin_valid       = margin_valid_r;
    assign overflow           = overflow_r;

endmodule

// File: tb/tb_span_position_loader.sv
// Scoreboard bench for span_position_loader: a cycle-level reference model predicts bus traffic,
// margin results and handshake state; an independent monitor checks what the DUT presents.
module tb_span_position_loader;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] psr_in = 16'h0000;
    logic        clear = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] margin;
    logic        margin_valid;
    logic        overflow;

    span_position_loader_if bus ();

    span_position_loader #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .bus(bus), .psr_in(psr_in), .clear(clear), .flush(flush),
        .busy(busy), .margin(margin), .margin_valid(margin_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; int a; int b; } exp_t;
    exp_t        wr_q[$];
    int          rd_q[$];
    exp_t        mv_q[$];
    logic [15:0] rdata_q[$];

    int  pos_m[8];
    bit  ovf_m;
    int  busy_cnt;
    int  rd_stage = 0;
    logic [15:0] rd_val;
    exp_t mon_e;
    int   mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_trade(input int c, input int q);
        int s;
        s = pos_m[c] + q;
`ifdef SPAN_LOADER_SAT_EN
        if (s > 32767) begin s = 32767; ovf_m = 1'b1; end
        else if (s < -32768) begin s = -32768; ovf_m = 1'b1; end
`else
        if (s > 32767) s = s - 65536;
        else if (s < -32768) s = s + 65536;
`endif
        pos_m[c] = s;
    endtask

    // Flush sampled at edge k: psr at cycle k, offsets 1..8 after, read, then result.
    task automatic push_flush(input int k, input logic [15:0] psr, input logic [15:0] rdat);
        wr_q.push_back('{k, 0, int'(psr)});
        for (int i = 0; i < 8; i++) wr_q.push_back('{k + 1 + i, i + 1, pos_m[i] & 32'h0000ffff});
        rd_q.push_back(k + 9 + S);
        mv_q.push_back('{k + 11 + S, int'(rdat), 0});
        rdata_q.push_back(rdat);
    endtask

    task automatic cycle(input bit v, input int c, input int q, input bit clr, input bit fl,
                         input logic [15:0] psr, input logic [15:0] rdat);
        bit idle;
        bus.trade_valid    = v;
        bus.trade_contract = 3'(c);
        bus.trade_qty      = 16'(q);
        clear  = clr;
        flush  = fl;
        psr_in = psr;
        idle   = (busy_cnt == 0);
        @(negedge clk);
        check("trade_ready", bus.trade_ready, idle && !clr);
        check("busy", busy, !idle);
        check("overflow", overflow, ovf_m);
        if (idle && clr) begin
            for (int i = 0; i < 8; i++) pos_m[i] = 0;
            ovf_m = 1'b0;
        end else if (idle) begin
            if (v) model_trade(c, q);
            if (fl) push_flush(cyc + 1, psr, rdat);
        end
        if (busy_cnt > 0) busy_cnt--;
        if (idle && fl && !clr) busy_cnt = 11 + S;
        @(posedge clk);
        #1;
        bus.trade_valid = 1'b0;
        clear = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cycle(1'b0, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear = 1'b0;
        flush = 1'b0;
        bus.trade_valid = 1'b1;
        @(posedge clk);
        #1;
        wr_q.delete(); rd_q.delete(); mv_q.delete(); rdata_q.delete();
        rd_stage = 0;
        for (int i = 0; i < 8; i++) pos_m[i] = 0;
        ovf_m = 1'b0;
        busy_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            check("rst_ready", bus.trade_ready, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_strobes", {bus.cme_chipselect, bus.cme_write, bus.cme_read}, 3'b000);
            check("rst_bus_fields", {bus.cme_offset, bus.cme_writeData}, 22'h0);
            check("rst_margin", {margin_valid, margin, overflow}, 18'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        bus.trade_valid = 1'b0;
    endtask

    // Bus/result monitor: every observed transfer must match the head of its queue.
    always @(negedge clk) begin
        if (bus.cme_write === 1'b1 && bus.cme_read === 1'b1) begin
            checks++; errors++;
            $display("FAIL strobe_overlap: write and read both 1 at cycle %0d, required at most one", cyc);
        end
        if ((bus.cme_write === 1'b1 || bus.cme_read === 1'b1) && bus.cme_chipselect !== 1'b1) begin
            checks++; errors++;
            $display("FAIL strobe_no_cs: chipselect %b with a strobe at cycle %0d, required 1", bus.cme_chipselect, cyc);
        end
        if (bus.cme_chipselect === 1'b1 && bus.cme_write === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: offset %0d data %h at cycle %0d, required no write", bus.cme_offset, bus.cme_writeData, cyc);
            end else begin
                mon_e = wr_q.pop_front();
                check("bus_write{cyc,off,data}", {32'(cyc), 16'(bus.cme_offset), bus.cme_writeData},
                      {32'(mon_e.cyc), 16'(mon_e.a), 16'(mon_e.b)});
            end
        end
        if (bus.cme_chipselect === 1'b1 && bus.cme_read === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: read at cycle %0d, required no read", cyc);
                rd_val = 16'($urandom);
            end else begin
                mon_r = rd_q.pop_front();
                check("bus_read{cyc,off}", {32'(cyc), 16'(bus.cme_offset)}, {32'(mon_r), 16'd0});
                rd_val = rdata_q.pop_front();
            end
            rd_stage = 1;
        end
        if (margin_valid === 1'b1) begin
            if (mv_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_margin_valid: margin %h at cycle %0d, required no pulse", margin, cyc);
            end else begin
                mon_e = mv_q.pop_front();
                check("margin{cyc,value}", {32'(cyc), margin}, {32'(mon_e.cyc), 16'(mon_e.a)});
            end
        end
    end

    // Peripheral stub: read data valid only in the cycle after the read strobe.
    initial begin
        bus.cme_readData = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (rd_stage == 1) begin
                bus.cme_readData = rd_val;
                rd_stage = 2;
            end else if (rd_stage == 2) begin
                bus.cme_readData = ~rd_val;
                rd_stage = 0;
            end
        end
    end

    initial begin
        bus.trade_valid    = 1'b0;
        bus.trade_contract = 3'd0;
        bus.trade_qty      = 16'h0000;
        do_reset(3);

        // Basic netting and load sequence.
        cycle(1'b1, 0, 5, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 0, -2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 7, 100, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 16'h0320, 16'h1234);
        idle_n(12 + S);
        check("margin_after_first_flush", margin, 16'h1234);

        // Trade offered while the sequencer is busy is refused, then accepted in IDLE.
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 16'h00aa, 16'h0bee);
        idle_n(3);
        cycle(1'b1, 3, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle_n(S + 9);
        cycle(1'b1, 3, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 4, -7, 1'b0, 1'b1, 16'hbeef, 16'h4321);
        idle_n(12 + S);

        // clear wins over flush; no bus activity follows.
        cycle(1'b1, 1, 9, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b0, 0, 0, 1'b1, 1'b1, 16'h0055, 16'h0000);
        idle_n(6);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 16'h0001, 16'h7777);
        idle_n(12 + S);

        // Positive boundary on contract 2, then negative boundary on contract 5.
        cycle(1'b1, 2, 32767, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 2, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 5, -32768, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 5, -1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 16'h1111, 16'h2222);
        idle_n(12 + S);

        // Reset during SETTLE aborts the sequence with no result.
        cycle(1'b1, 6, 42, 1'b0, 1'b1, 16'h3333, 16'h4444);
        idle_n(10);
        do_reset(2);
        idle_n(2 * S + 16);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 16'h5555, 16'h6666);
        idle_n(12 + S);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            int q;
            if ($urandom_range(3) == 0) q = int'($signed(16'($urandom)));
            else q = int'($urandom_range(100)) - 50;
            cycle($urandom_range(9) < 7, int'($urandom_range(7)), q,
                  $urandom_range(49) == 0, $urandom_range(24) == 0,
                  16'($urandom), 16'($urandom));
        end
        idle_n(2 * S + 20);

        check("drain_writes", 64'(wr_q.size()), 64'd0);
        check("drain_reads", 64'(rd_q.size()), 64'd0);
        check("drain_margins", 64'(mv_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
